ps2_morse_encoder: RTL and testbench

- Receives PS/2 keyboard scancodes (set 2, device-to-host only) and buffers the typed letters, digits and spaces.
- On Enter, plays the buffered message as Morse code on dit/dah indicator outputs and a square-wave audio output.
- Top of the keyboard-to-Morse datapath: a PS/2 receiver feeds the encoder FSM, which drives the tone generator.

---
 rtl/ps2_morse_pkg.sv | 77 +++++++
 rtl/ps2_rx.sv | 83 ++++++++
 rtl/ps2_morse_encoder.sv | 185 ++++++++++++++++++
 tb/tb_ps2_morse_encoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_morse_pkg.sv
// Shared types, scancode constants and the scancode-to-Morse table.
package ps2_morse_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_SPACE = 8'h29;

    typedef enum logic [2:0] {IDLE, ELEM, GAP, CHARGAP, WORDGAP} state_e;

    // len = number of elements (0 = word space); pat is right-aligned,
    // first element in pat[len-1], 1 = dah.
    typedef struct packed {
        logic [2:0] len;
        logic [4:0] pat;
    } entry_t;

    typedef struct packed {
        logic   hit;
        entry_t ent;
    } lookup_t;

    function automatic entry_t mk(input logic [2:0] len, input logic [4:0] pat);
        entry_t e;
        e.len = len;
        e.pat = pat;
        return e;
    endfunction

    function automatic lookup_t morse_lookup(input logic [7:0] code);
        lookup_t r;
        r.hit = 1'b1;
        r.ent = '0;
        case (code)
            8'h1C: r.ent = mk(3'd2, 5'b00001); // A .-
            8'h32: r.ent = mk(3'd4, 5'b01000); // B -...
            8'h21: r.ent = mk(3'd4, 5'b01010); // C -.-.
            8'h23: r.ent = mk(3'd3, 5'b00100); // D -..
            8'h24: r.ent = mk(3'd1, 5'b00000); // E .
            8'h2B: r.ent = mk(3'd4, 5'b00010); // F ..-.
            8'h34: r.ent = mk(3'd3, 5'b00110); // G --.
            8'h33: r.ent = mk(3'd4, 5'b00000); // H ....
            8'h43: r.ent = mk(3'd2, 5'b00000); // I ..
            8'h3B: r.ent = mk(3'd4, 5'b00111); // J .---
            8'h42: r.ent = mk(3'd3, 5'b00101); // K -.-
            8'h4B: r.ent = mk(3'd4, 5'b00100); // L .-..
            8'h3A: r.ent = mk(3'd2, 5'b00011); // M --
            8'h31: r.ent = mk(3'd2, 5'b00010); // N -.
            8'h44: r.ent = mk(3'd3, 5'b00111); // O ---
            8'h4D: r.ent = mk(3'd4, 5'b00110); // P .--.
            8'h15: r.ent = mk(3'd4, 5'b01101); // Q --.-
            8'h2D: r.ent = mk(3'd3, 5'b00010); // R .-.
            8'h1B: r.ent = mk(3'd3, 5'b00000); // S ...
            8'h2C: r.ent = mk(3'd1, 5'b00001); // T -
            8'h3C: r.ent = mk(3'd3, 5'b00001); // U ..-
            8'h2A: r.ent = mk(3'd4, 5'b00001); // V ...-
            8'h1D: r.ent = mk(3'd3, 5'b00011); // W .--
            8'h22: r.ent = mk(3'd4, 5'b01001); // X -..-
            8'h35: r.ent = mk(3'd4, 5'b01011); // Y -.--
            8'h1A: r.ent = mk(3'd4, 5'b01100); // Z --..
            8'h45: r.ent = mk(3'd5, 5'b11111); // 0
            8'h16: r.ent = mk(3'd5, 5'b01111); // 1
            8'h1E: r.ent = mk(3'd5, 5'b00111); // 2
            8'h26: r.ent = mk(3'd5, 5'b00011); // 3
            8'h25: r.ent = mk(3'd5, 5'b00001); // 4
            8'h2E: r.ent = mk(3'd5, 5'b00000); // 5
            8'h36: r.ent = mk(3'd5, 5'b10000); // 6
            8'h3D: r.ent = mk(3'd5, 5'b11000); // 7
            8'h3E: r.ent = mk(3'd5, 5'b11100); // 8
            8'h46: r.ent = mk(3'd5, 5'b11110); // 9
            SC_SPACE: r.ent = mk(3'd0, 5'b00000);
            default: r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronizers, falling-edge
// sampling, frame checks and a mid-frame inactivity timeout.
module ps2_rx #(
    parameter int TIMEOUT = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       strobe
);

    localparam int TW = $clog2(TIMEOUT + 1);

    // [1:0] synchronizer, [2] previous synchronized value for edge detect
    logic [2:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    frame_q, frame_d;
    logic [TW-1:0] idle_q, idle_d;
    logic [7:0]    code_q, code_d;
    logic          strobe_q, strobe_d;
    logic          fall;

    assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
    assign code   = code_q;
    assign strobe = strobe_q;

    // Frame assembly: bits shift in at the top, so after ten edges
    // frame[0] = start, frame[8:1] = data, frame[9] = parity.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        idle_d    = idle_q;
        code_d    = code_q;
        strobe_d  = 1'b0;
        if (fall) begin
            idle_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = '0;
                if (!frame_q[0] && (^frame_q[9:1]) && dat_sync_q[1]) begin
                    strobe_d = 1'b1;
                    code_d   = frame_q[8:1];
                end
            end else begin
                frame_d   = {dat_sync_q[1], frame_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (idle_q == TW'(TIMEOUT - 1)) begin
                bit_cnt_d = '0;
                idle_d    = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end else begin
            idle_d = '0;
        end
    end

    // Registers; synchronizers reset to the idle-high line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            bit_cnt_q  <= '0;
            frame_q    <= '0;
            idle_q     <= '0;
            code_q     <= '0;
            strobe_q   <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            idle_q     <= idle_d;
            code_q     <= code_d;
            strobe_q   <= strobe_d;
        end
    end

endmodule

// File: rtl/ps2_morse_encoder.sv
// Keyboard-to-Morse top: buffers decoded keys, plays them on Enter as
// dit/dah indicators with a gated square-wave tone.
module ps2_morse_encoder
    import ps2_morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 3_000_000,
    parameter int TONE_HALF   = 41_667,
    parameter int PS2_TIMEOUT = 100_000,
    parameter int DEPTH       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic dit_out,
    output logic dah_out,
    output logic tone_out,
    output logic busy
);

    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int UW  = $clog2(UNIT_CYCLES + 1);
    localparam int HW  = $clog2(TONE_HALF + 1);

    logic [7:0]    rx_code;
    logic          rx_stb;

    state_e        state_q, state_d;
    entry_t        buf_q [DEPTH];
    entry_t        buf_d [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] rd_q, rd_d, rd_nxt;
    logic [2:0]    elem_q, elem_d;
    logic [UW-1:0] cyc_q, cyc_d;
    logic [2:0]    unit_q, unit_d;
    logic          brk_q, brk_d;
    logic [HW-1:0] tcnt_q, tcnt_d;
    logic          tone_q, tone_d;

    entry_t        cur;
    logic [7:0]    pat_ext;
    logic [2:0]    bit_idx;
    logic          cur_bit;
    logic [2:0]    dur;
    logic          unit_end, phase_end, on;
    lookup_t       lk;

    ps2_rx #(.TIMEOUT(PS2_TIMEOUT)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .code     (rx_code),
        .strobe   (rx_stb)
    );

    // Current element and the length (in units) of the present phase.
    always_comb begin
        cur     = buf_q[rd_q];
        pat_ext = {3'b000, cur.pat};
        bit_idx = cur.len - 3'd1 - elem_q;
        cur_bit = pat_ext[bit_idx];
        rd_nxt  = rd_q + 1'b1;
        case (state_q)
            ELEM:    dur = cur_bit ? 3'd3 : 3'd1;
            GAP:     dur = 3'd1;
            CHARGAP: dur = 3'd3;
            WORDGAP: dur = 3'd4;
            default: dur = 3'd1;
        endcase
        unit_end  = (cyc_q == UW'(UNIT_CYCLES - 1));
        phase_end = unit_end && (unit_q == dur - 3'd1);
        on        = (state_q == ELEM);
    end

    // Encoder FSM: key decode and buffering in IDLE, timed playback otherwise.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        elem_d  = elem_q;
        cyc_d   = cyc_q;
        unit_d  = unit_q;
        brk_d   = brk_q;
        lk      = morse_lookup(rx_code);
        if (state_q == IDLE) begin
            cyc_d  = '0;
            unit_d = '0;
            if (rx_stb) begin
                if (brk_q) begin
                    brk_d = 1'b0;              // release code: swallow it
                end else if (rx_code == SC_BREAK) begin
                    brk_d = 1'b1;
                end else if (rx_code == SC_ENTER) begin
                    if (cnt_q != '0) begin
                        rd_d    = '0;
                        elem_d  = '0;
                        state_d = (buf_q[0].len == 3'd0) ? WORDGAP : ELEM;
                    end
                end else if (lk.hit && (cnt_q < CW'(DEPTH))) begin
                    buf_d[cnt_q[IW-1:0]] = lk.ent;
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end else begin
            cyc_d = unit_end ? '0 : cyc_q + 1'b1;
            if (unit_end) unit_d = unit_q + 3'd1;
            if (phase_end) begin
                unit_d = '0;
                case (state_q)
                    ELEM: begin
                        if (elem_q == cur.len - 3'd1) begin
                            state_d = CHARGAP;
                        end else begin
                            state_d = GAP;
                            elem_d  = elem_q + 3'd1;
                        end
                    end
                    GAP: state_d = ELEM;
                    default: begin
                        if (CW'(rd_q) == cnt_q - 1'b1) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            rd_d    = '0;
                        end else begin
                            rd_d    = rd_nxt;
                            elem_d  = '0;
                            state_d = (buf_q[rd_nxt].len == 3'd0) ? WORDGAP : ELEM;
                        end
                    end
                endcase
            end
        end
    end

    // Tone divider: free-runs only during an element, cleared otherwise.
    always_comb begin
        tcnt_d = tcnt_q;
        tone_d = tone_q;
        if (!on) begin
            tcnt_d = '0;
            tone_d = 1'b0;
        end else if (tcnt_q == HW'(TONE_HALF - 1)) begin
            tcnt_d = '0;
            tone_d = ~tone_q;
        end else begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            buf_q   <= '{default: '0};
            cnt_q   <= '0;
            rd_q    <= '0;
            elem_q  <= '0;
            cyc_q   <= '0;
            unit_q  <= '0;
            brk_q   <= 1'b0;
            tcnt_q  <= '0;
            tone_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            elem_q  <= elem_d;
            cyc_q   <= cyc_d;
            unit_q  <= unit_d;
            brk_q   <= brk_d;
            tcnt_q  <= tcnt_d;
            tone_q  <= tone_d;
        end
    end

    assign dit_out  = on & ~cur_bit;
    assign dah_out  = on &  cur_bit;
    assign tone_out = tone_q & on;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_morse_encoder.sv
// Directed bench: drives PS/2 frames, records the dit/dah/silence run
// lengths during playback and compares them with hand-written Morse.
`timescale 1ns/1ps
module tb_ps2_morse_encoder;

    localparam int UNIT = 200;   // clk cycles per Morse unit
    localparam int TH   = 20;    // tone half period
    localparam int TO   = 500;   // PS/2 timeout
    localparam int H    = 20;    // PS/2 clock half period in clk cycles
    localparam int K    = 100000; // run-kind multiplier in the run encoding

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic dit_out, dah_out, tone_out, busy;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    ps2_morse_encoder #(
        .UNIT_CYCLES (UNIT),
        .TONE_HALF   (TH),
        .PS2_TIMEOUT (TO),
        .DEPTH       (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .dit_out  (dit_out),
        .dah_out  (dah_out),
        .tone_out (tone_out),
        .busy     (busy)
    );

    // Run recorder: kind (0 silent, 1 dit, 2 dah) * K + length in cycles.
    int   runs[$];
    int   exp_q[$];
    int   cnt = 0, toggles = 0, viol = 0, act = 0;
    logic [1:0] prev_lvl = 2'b00;
    logic prev_busy = 1'b0, prev_tone = 1'b0;

    always @(negedge clk) begin
        logic [1:0] lvl;
        lvl = {dah_out, dit_out};
        if (lvl == 2'b11) viol++;
        if (lvl == 2'b00 && tone_out) viol++;
        if (lvl != 2'b00) act++;
        if (prev_busy && (!busy || lvl != prev_lvl)) begin
            runs.push_back(int'(prev_lvl) * K + cnt);
            cnt = 0;
        end
        if (busy) begin
            if (lvl != 2'b00 && tone_out !== prev_tone) begin
                toggles++;
                if (cnt == 0 || (cnt % TH) != 0) viol++;
            end
            cnt++;
        end else begin
            cnt = 0;
        end
        prev_lvl  = lvl;
        prev_busy = busy;
        prev_tone = tone_out;
    end

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] c, input bit badpar = 1'b0);
        logic [10:0] f;
        f = {1'b1, (~(^c)) ^ badpar, c, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = f[i];
            tick(H);
            ps2_clk = 1'b0;
            tick(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(3 * H);
    endtask

    task automatic clear();
        runs.delete();
        exp_q.delete();
        toggles = 0;
        act = 0;
    endtask

    task automatic exp_char(input string m);
        for (int i = 0; i < m.len(); i++) begin
            exp_q.push_back((m[i] == "-") ? 2 * K + 3 * UNIT : 1 * K + UNIT);
            exp_q.push_back((i == m.len() - 1) ? 3 * UNIT : UNIT);
        end
    endtask

    task automatic exp_space();
        if (exp_q.size() == 0) exp_q.push_back(4 * UNIT);
        else exp_q[exp_q.size() - 1] += 4 * UNIT;
    endtask

    task automatic wait_busy(input bit lvl, input int budget, input string tag);
        int n;
        n = 0;
        while (busy !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(busy), int'(lvl));
    endtask

    task automatic play(input string tag);
        send(8'h5A);
        wait_busy(1'b1, 2000, {tag, " busy rise"});
        wait_busy(1'b0, 40000, {tag, " busy fall"});
        tick(4);
        check({tag, " run count"}, runs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < runs.size(); i++)
            check($sformatf("%s run[%0d]", tag, i), runs[i], exp_q[i]);
    endtask

    task automatic check_silent(input string tag);
        tick(2000);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " activity"}, act, 0);
        check({tag, " runs"}, runs.size(), 0);
    endtask

    initial begin
        // reset state
        tick(5);
        @(negedge clk);
        check("rst dit", int'(dit_out), 0);
        check("rst dah", int'(dah_out), 0);
        check("rst tone", int'(tone_out), 0);
        check("rst busy", int'(busy), 0);
        rst = 1'b1;
        tick(5);

        // A then Enter: dit, gap, dah, tone only while on
        clear();
        send(8'h1C);
        exp_char(".-");
        play("t1");
        check("t1 toggles", toggles, 9 + 29);
        check("t1 viol", viol, 0);

        // A, Space, B: 7-unit silence between words
        clear();
        send(8'h1C); send(8'h29); send(8'h32);
        exp_char(".-"); exp_space(); exp_char("-...");
        play("t2");

        // break flag suppresses C
        clear();
        send(8'h1C); send(8'hF0); send(8'h21); send(8'h1C);
        exp_char(".-"); exp_char(".-");
        play("t3");

        // bad parity frame is dropped; Enter on empty buffer does nothing
        clear();
        send(8'h21, 1'b1);
        send(8'h5A);
        check_silent("t4");

        // 17 E's: only 16 fit
        clear();
        for (int i = 0; i < 17; i++) send(8'h24);
        for (int i = 0; i < 16; i++) exp_char(".");
        play("t5");

        // keys without Enter, plus an unmapped 0x0C: nothing plays
        clear();
        send(8'h1C); send(8'h32); send(8'h21); send(8'h0C); send(8'h29);
        check_silent("t6");

        // play the buffered keys, reset during a dah
        clear();
        send(8'h5A);
        begin
            int n;
            n = 0;
            while (dah_out !== 1'b1 && n < 5000) begin
                @(negedge clk);
                n++;
            end
            check("t7 dah seen", int'(dah_out), 1);
        end
        #2 rst = 1'b0;
        #1;
        check("t7 rst dit", int'(dit_out), 0);
        check("t7 rst dah", int'(dah_out), 0);
        check("t7 rst tone", int'(tone_out), 0);
        check("t7 rst busy", int'(busy), 0);
        tick(3);
        rst = 1'b1;
        tick(5);
        clear();
        send(8'h5A);
        check_silent("t7 after rst");

        // partial frame abandoned by timeout, then a clean A
        clear();
        ps2_data = 1'b0; tick(H); ps2_clk = 1'b0; tick(H); ps2_clk = 1'b1;
        ps2_data = 1'b1; tick(H); ps2_clk = 1'b0; tick(H); ps2_clk = 1'b1;
        ps2_data = 1'b0; tick(H); ps2_clk = 1'b0; tick(H); ps2_clk = 1'b1;
        ps2_data = 1'b1;
        tick(2 * TO);
        send(8'h1C);
        exp_char(".-");
        play("t8");

        check("viol total", viol, 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
